mc_port_arbiter: RTL
====================

MC_PORT_ARBITER -- requirements
Module: mc_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one MC port (range 2..8).
REQ-002 SHALL have parameter RTNCTL_WIDTH, default 32, width of the MC rtnctl field.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 16, the per-requester in-flight read/write limit (range 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic runs on clk.
REQ-005 SHALL have port i_reset, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports req_vld / req_stall, input / output, NUM_REQ, carrying per-requester request valid and backpressure.
REQ-007 SHALL have ports req_cmd, req_scmd, req_size, req_vadr, req_data and req_tag, all inputs, with widths NUM_REQ*3, *4, *2, *48, *64 and *16, carrying packed per-requester request fields.
REQ-008 SHALL have ports mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data and mc_rq_rtnctl, all outputs, with widths 1, 3, 4, 2, 48, 64 and RTNCTL_WIDTH, plus input mc_rq_stall, 1, forming the MC request port.
REQ-009 SHALL have inputs mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data and mc_rs_rtnctl, with widths 1, 3, 4, 64 and RTNCTL_WIDTH, plus output mc_rs_stall, 1, forming the MC response port.
REQ-010 SHALL have outputs rsp_vld (NUM_REQ), rsp_cmd (3), rsp_scmd (4), rsp_data (64) and rsp_tag (16), plus input rsp_stall (NUM_REQ), forming the routed response port.
REQ-011 SHALL have input req_flush (NUM_REQ) and output flush_cmplt (NUM_REQ), the per-requester flush handshake.
REQ-012 SHALL have output mc_rq_flush (1) and input mc_rs_flush_cmplt (1), the MC flush handshake.
REQ-013 SHALL have outputs idle (1), err_bad_id (1) and grant_cnt (NUM_REQ*32).

Function
REQ-014 SHALL hold a one-entry registered output stage driving all mc_rq_* signals.
- A request accepted on cycle N (req_vld[i] & !req_stall[i]) appears on mc_rq_vld at N+1.
REQ-015 SHALL hold the output entry unchanged while mc_rq_vld & mc_rq_stall.
- The entry is reloadable on the same cycle it drains (mc_rq_vld & !mc_rq_stall), allowing back-to-back issue.
REQ-016 SHALL arbitrate among eligible requesters round-robin.
- Eligible means: req_vld high, outstanding count below MAX_OUTSTANDING, and FSM in RUN.
- The pointer advances to (granted+1) mod NUM_REQ only on a grant.
- After reset the pointer is 0.
REQ-017 SHALL deassert req_stall only for the single granted requester; all others are stalled that cycle.
REQ-018 SHALL form mc_rq_rtnctl = {zero pad, 8-bit requester id, req_tag}, with id in bits [23:16] and tag in [15:0].
REQ-019 SHALL keep a per-requester outstanding counter.
- Increment on grant; decrement when that requester's response is accepted (rsp_vld & !rsp_stall).
- Simultaneous increment and decrement leave the count unchanged.
- The count never wraps.
REQ-020 SHALL route mc_rs_* combinationally to requester id = mc_rs_rtnctl[23:16]:
- rsp_vld[id] = mc_rs_vld;
- rsp_tag = mc_rs_rtnctl[15:0];
- mc_rs_stall = rsp_stall[id].
REQ-021 SHALL drop responses with id >= NUM_REQ (mc_rs_stall 0, no rsp_vld) and set sticky err_bad_id, which is cleared only by reset.
REQ-022 SHALL implement flush FSM RUN -> DRAIN -> FLUSH -> WAIT -> RUN.
- RUN->DRAIN: any req_flush high; latch the mask.
- DRAIN->FLUSH: output stage empty.
- FLUSH: mc_rq_flush high exactly one cycle, then go to WAIT.
- WAIT->RUN: on mc_rs_flush_cmplt; pulse flush_cmplt for the latched mask for one cycle.
REQ-023 SHALL OR req_flush into the latched mask while in DRAIN or FLUSH; flushes raised in WAIT are serviced by a new pass after returning to RUN.
REQ-024 SHALL make no grants outside RUN; responses continue to route in all states.
REQ-025 SHALL drive idle = RUN & output stage empty & all outstanding counters zero.

Reset
REQ-026 SHALL, on i_reset, asynchronously set the following to zero:
- mc_rq_vld, mc_rq_flush, flush_cmplt, err_bad_id, all counters, the pointer and the mask;
- FSM to RUN; req_stall to all-ones.
REQ-027 SHALL discard any held output entry and pending flush when reset is asserted mid-operation, with no flush_cmplt generated.

Configuration
REQ-028 SHALL, when MC_ARB_STATS_EN is defined, provide a 32-bit wrapping grant counter per requester on grant_cnt, incremented on each grant.
REQ-029 SHALL, when MC_ARB_STATS_EN is undefined, tie grant_cnt to 0 and instantiate no counter registers.

Verification
REQ-030 SHALL verify that req_vld=2'b11 held for 4 cycles, with no stall, gives grant order 0,1,0,1, rtnctl ids 0,1,0,1, and mc_rq_vld from cycle 1.
REQ-031 SHALL verify that mc_rq_stall held for 3 cycles keeps mc_rq_vadr unchanged, holds req_stall=2'b11, and resumes issue on the cycle after release.
REQ-032 SHALL verify that, with MAX_OUTSTANDING=2, requester 0 issuing 3 reads with no responses causes the third to stall until one response with rtnctl[23:16]=0 is accepted.
REQ-033 SHALL verify that a response with rtnctl=0x0001_00AB gives rsp_vld=2'b10 and rsp_tag=0x00AB, and that asserting rsp_stall[1] forces mc_rs_stall=1.
REQ-034 SHALL verify that req_flush[0] in RUN and req_flush[1] during DRAIN give one mc_rq_flush pulse and, after mc_rs_flush_cmplt, flush_cmplt=2'b11 for one cycle.
REQ-035 SHALL verify that a response with rtnctl[23:16]=5 (NUM_REQ=2) is dropped, sets err_bad_id=1, and leaves the counters unchanged.

Source files
------------

// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter sharing one MC request/response port among NUM_REQ requesters.
// Optional per-requester grant counters: define MC_ARB_STATS_EN.
module mc_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int RTNCTL_WIDTH    = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      req_vld,
  output logic [NUM_REQ-1:0]      req_stall,
  input  logic [NUM_REQ*3-1:0]    req_cmd,
  input  logic [NUM_REQ*4-1:0]    req_scmd,
  input  logic [NUM_REQ*2-1:0]    req_size,
  input  logic [NUM_REQ*48-1:0]   req_vadr,
  input  logic [NUM_REQ*64-1:0]   req_data,
  input  logic [NUM_REQ*16-1:0]   req_tag,
  output logic                    mc_rq_vld,
  output logic [2:0]              mc_rq_cmd,
  output logic [3:0]              mc_rq_scmd,
  output logic [1:0]              mc_rq_size,
  output logic [47:0]             mc_rq_vadr,
  output logic [63:0]             mc_rq_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic                    mc_rq_stall,
  input  logic                    mc_rs_vld,
  input  logic [2:0]              mc_rs_cmd,
  input  logic [3:0]              mc_rs_scmd,
  input  logic [63:0]             mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  output logic                    mc_rs_stall,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic [2:0]              rsp_cmd,
  output logic [3:0]              rsp_scmd,
  output logic [63:0]             rsp_data,
  output logic [15:0]             rsp_tag,
  input  logic [NUM_REQ-1:0]      rsp_stall,
  input  logic [NUM_REQ-1:0]      req_flush,
  output logic [NUM_REQ-1:0]      flush_cmplt,
  output logic                    mc_rq_flush,
  input  logic                    mc_rs_flush_cmplt,
  output logic                    idle,
  output logic                    err_bad_id,
  output logic [NUM_REQ*32-1:0]   grant_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_RUN, S_DRAIN, S_FLUSH, S_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q [NUM_REQ];
  logic [7:0] cnt_d [NUM_REQ];
  logic err_q, err_d;

  logic out_vld_q, out_vld_d;
  logic [2:0] out_cmd_q, out_cmd_d;
  logic [3:0] out_scmd_q, out_scmd_d;
  logic [1:0] out_size_q, out_size_d;
  logic [47:0] out_vadr_q, out_vadr_d;
  logic [63:0] out_data_q, out_data_d;
  logic [RTNCTL_WIDTH-1:0] out_rtn_q, out_rtn_d;

  logic load_ok;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_oh;
  logic gnt;
  logic [PW-1:0] gnt_id;
  int rr_idx;

  logic [7:0] rs_id;
  logic rs_bad;
  logic [NUM_REQ-1:0] rsp_acc;
  logic cnt_zero;
  logic unused_rtn;

  // Reset gates eligibility so req_stall reads all-ones while reset is held.
  always_comb begin
    load_ok = !out_vld_q || !mc_rq_stall;
    elig    = '0;
    gnt     = 1'b0;
    gnt_id  = '0;
    rr_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_vld[i] && (cnt_q[i] < 8'(MAX_OUTSTANDING)) &&
                (state_q == S_RUN) && load_ok && !i_reset;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt && elig[rr_idx]) begin
        gnt    = 1'b1;
        gnt_id = PW'(rr_idx);
      end
    end
    gnt_oh = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
    if (!gnt) ptr_d = ptr_q;
    else if (gnt_id == PW'(NUM_REQ - 1)) ptr_d = '0;
    else ptr_d = gnt_id + PW'(1);
  end

  assign req_stall = ~gnt_oh;

  always_comb begin
    out_vld_d  = out_vld_q && mc_rq_stall;
    out_cmd_d  = out_cmd_q;
    out_scmd_d = out_scmd_q;
    out_size_d = out_size_q;
    out_vadr_d = out_vadr_q;
    out_data_d = out_data_q;
    out_rtn_d  = out_rtn_q;
    if (gnt) begin
      out_vld_d  = 1'b1;
      out_cmd_d  = req_cmd[int'(gnt_id)*3 +: 3];
      out_scmd_d = req_scmd[int'(gnt_id)*4 +: 4];
      out_size_d = req_size[int'(gnt_id)*2 +: 2];
      out_vadr_d = req_vadr[int'(gnt_id)*48 +: 48];
      out_data_d = req_data[int'(gnt_id)*64 +: 64];
      out_rtn_d  = '0;
      out_rtn_d[23:16] = 8'(gnt_id);
      out_rtn_d[15:0]  = req_tag[int'(gnt_id)*16 +: 16];
    end
  end

  assign rs_id  = mc_rs_rtnctl[23:16];
  assign rs_bad = rs_id >= 8'(NUM_REQ);
  assign unused_rtn = &{1'b0, mc_rs_rtnctl};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld[i] = mc_rs_vld && !rs_bad && (rs_id == 8'(i));
      rsp_acc[i] = rsp_vld[i] && !rsp_stall[i];
    end
  end

  assign mc_rs_stall = !rs_bad && rsp_stall[rs_id[PW-1:0]];
  assign rsp_cmd     = mc_rs_cmd;
  assign rsp_scmd    = mc_rs_scmd;
  assign rsp_data    = mc_rs_data;
  assign rsp_tag     = mc_rs_rtnctl[15:0];
  assign err_d       = err_q || (mc_rs_vld && rs_bad);

  // Increment is bounded by eligibility, decrement by the zero test.
  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_oh[i] && !(rsp_acc[i] && cnt_q[i] != 8'd0))
        cnt_d[i] = cnt_q[i] + 8'd1;
      else if (!gnt_oh[i] && rsp_acc[i] && cnt_q[i] != 8'd0)
        cnt_d[i] = cnt_q[i] - 8'd1;
      if (cnt_q[i] != 8'd0) cnt_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_RUN: begin
        if (|req_flush) begin
          state_d = S_DRAIN;
          mask_d  = req_flush;
        end
      end
      S_DRAIN: begin
        mask_d = mask_q | req_flush;
        if (!out_vld_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        mask_d  = mask_q | req_flush;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mc_rs_flush_cmplt) begin
          state_d = S_RUN;
          mask_d  = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign mc_rq_flush = (state_q == S_FLUSH);
  assign flush_cmplt = (state_q == S_WAIT && mc_rs_flush_cmplt) ? mask_q : '0;
  assign idle = (state_q == S_RUN) && !out_vld_q && cnt_zero;
  assign err_bad_id = err_q;

  assign mc_rq_vld    = out_vld_q;
  assign mc_rq_cmd    = out_cmd_q;
  assign mc_rq_scmd   = out_scmd_q;
  assign mc_rq_size   = out_size_q;
  assign mc_rq_vadr   = out_vadr_q;
  assign mc_rq_data   = out_data_q;
  assign mc_rq_rtnctl = out_rtn_q;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_RUN;
      mask_q     <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_cmd_q  <= '0;
      out_scmd_q <= '0;
      out_size_q <= '0;
      out_vadr_q <= '0;
      out_data_q <= '0;
      out_rtn_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      out_vld_q  <= out_vld_d;
      out_cmd_q  <= out_cmd_d;
      out_scmd_q <= out_scmd_d;
      out_size_q <= out_size_d;
      out_vadr_q <= out_vadr_d;
      out_data_q <= out_data_d;
      out_rtn_q  <= out_rtn_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MC_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt_oh[i]) gcnt_q[i] <= gcnt_q[i] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*32 +: 32] = gcnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
